// File: rtl/alu_mult_unit.sv
// EX-stage integer unit: combinational one-hot ALU (incl. restoring-array unsigned divide) plus a
// 32-step signed shift-add multiplier; mult_end rises 33 edges after sampling, held while MUL stays set.
module alu_mult_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] alu_control,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result,
  output logic [31:0] div_odd,
  output logic [63:0] product,
  output logic        mult_end
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_mcand, r_acc, r_product;
  logic [32:0] r_mplier;
  logic        r_neg, r_mult_end;

  logic        w_begin;
  logic [4:0]  w_sh;
  logic [32:0] w_mag_a, w_mag_b;
  logic [31:0] w_quo, w_rem;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_add, w_sub, w_slt, w_sltu, w_and, w_nor, w_or, w_xor;
  logic [31:0] w_sll, w_lui, w_srl, w_sra;

  assign w_begin = alu_control[2];
  assign w_sh    = alu_src1[4:0];

  assign w_add  = alu_src1 + alu_src2;
  assign w_sub  = alu_src1 - alu_src2;
  assign w_slt  = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
  assign w_sltu = {31'b0, alu_src1 < alu_src2};
  assign w_and  = alu_src1 & alu_src2;
  assign w_nor  = ~(alu_src1 | alu_src2);
  assign w_or   = alu_src1 | alu_src2;
  assign w_xor  = alu_src1 ^ alu_src2;
  assign w_sll  = alu_src2 << w_sh;
  assign w_lui  = {alu_src2[15:0], 16'h0};
  assign w_srl  = alu_src2 >> w_sh;
  assign w_sra  = $unsigned($signed(alu_src2) >>> w_sh);

  // Restoring division; a zero divisor naturally yields all-ones quotient and remainder = dividend.
  always_comb begin
    w_quo   = '0;
    w_rem   = '0;
    w_trial = '0;
    w_ge    = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      w_trial  = {w_rem, alu_src1[i]};
      w_ge     = (w_trial >= {1'b0, alu_src2});
      w_quo[i] = w_ge;
      w_rem    = w_ge ? (w_trial[31:0] - alu_src2) : w_trial[31:0];
    end
  end

  assign alu_result = ({32{alu_control[0]}}  & w_add)  |
                      ({32{alu_control[1]}}  & w_sub)  |
                      ({32{alu_control[3]}}  & w_quo)  |
                      ({32{alu_control[4]}}  & w_slt)  |
                      ({32{alu_control[5]}}  & w_sltu) |
                      ({32{alu_control[6]}}  & w_and)  |
                      ({32{alu_control[7]}}  & w_nor)  |
                      ({32{alu_control[8]}}  & w_or)   |
                      ({32{alu_control[9]}}  & w_xor)  |
                      ({32{alu_control[10]}} & w_sll)  |
                      ({32{alu_control[11]}} & w_lui)  |
                      ({32{alu_control[12]}} & w_srl)  |
                      ({32{alu_control[13]}} & w_sra);
  assign div_odd    = {32{alu_control[3]}} & w_rem;

  // 33-bit magnitudes so that -2^31 maps cleanly to +2^31.
  assign w_mag_a = alu_src1[31] ? (33'd0 - {1'b1, alu_src1}) : {1'b0, alu_src1};
  assign w_mag_b = alu_src2[31] ? (33'd0 - {1'b1, alu_src2}) : {1'b0, alu_src2};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_begin) w_next = S_BUSY;
      S_BUSY:  if (!w_begin) w_next = S_IDLE;
               else if (r_cnt == 6'd32) w_next = S_DONE;
      S_DONE:  if (!w_begin) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_product  <= '0;
      r_mult_end <= 1'b0;
    end else begin
      r_mult_end <= (w_next == S_DONE);
      if (r_state == S_IDLE && w_begin) begin
        r_mcand  <= {31'b0, w_mag_a};
        r_mplier <= w_mag_b;
        r_acc    <= '0;
        r_neg    <= alu_src1[31] ^ alu_src2[31];
        r_cnt    <= '0;
      end else if (r_state == S_BUSY && w_begin) begin
        if (r_cnt == 6'd32) begin
          r_product <= r_neg ? (64'd0 - r_acc) : r_acc;
        end else begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 6'd1;
        end
      end
    end
  end

  assign product  = r_product;
  assign mult_end = r_mult_end;

endmodule

// File: tb/tb_alu_mult_unit.sv
// Randomised scoreboard bench for alu_mult_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_alu_mult_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [13:0] ctl = '0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] alu_result, div_odd;
  logic [63:0] product;
  logic        mult_end;

  alu_mult_unit dut (
    .clk(clk), .resetn(resetn), .alu_control(ctl), .alu_src1(a), .alu_src2(b),
    .alu_result(alu_result), .div_odd(div_odd), .product(product), .mult_end(mult_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
  } alu_exp_t;

  alu_exp_t    alu_q[$];
  logic [63:0] mul_q[$];
  int          mul_t_q[$];
  int          n_vec = 0, n_bad = 0, n_done = 0;

  function automatic alu_exp_t model(input logic [13:0] c, input logic [31:0] x, input logic [31:0] y);
    alu_exp_t    e;
    logic [63:0] ext;
    int unsigned sh;
    sh    = int'(x[4:0]);
    ext   = {{32{y[31]}}, y} >> sh;
    e.res = '0;
    e.rem = '0;
    if (c[0])  e.res |= x + y;
    if (c[1])  e.res |= x - y;
    if (c[3])  begin
      e.res |= (y == 0) ? 32'hFFFF_FFFF : x / y;
      e.rem  = (y == 0) ? x : x % y;
    end
    if (c[4])  e.res |= ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    if (c[5])  e.res |= (x < y) ? 32'd1 : 32'd0;
    if (c[6])  e.res |= x & y;
    if (c[7])  e.res |= ~(x | y);
    if (c[8])  e.res |= x | y;
    if (c[9])  e.res |= x ^ y;
    if (c[10]) e.res |= y << sh;
    if (c[11]) e.res |= y * 32'h10000;
    if (c[12]) e.res |= y >> sh;
    if (c[13]) e.res |= ext[31:0];
    return e;
  endfunction

  function automatic logic [63:0] mul_model(input logic [31:0] x, input logic [31:0] y);
    longint px, py;
    px = longint'($signed(x));
    py = longint'($signed(y));
    return 64'(px * py);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Called at posedge+1; leaves the caller at the next posedge+1.
  task automatic apply(input logic [13:0] c, input logic [31:0] x, input logic [31:0] y);
    ctl = c;
    a   = x;
    b   = y;
    alu_q.push_back(model(c, x, y));
    @(posedge clk); #1;
  endtask

  task automatic wait_mul(input int start);
    int budget;
    budget = 0;
    while (n_done == start && budget < 60) begin
      @(posedge clk); #1;
      budget++;
    end
    if (n_done == start) begin
      n_vec++;
      n_bad++;
      $display("FAIL mult_end_timeout: got no mult_end expected one within 60 cycles");
    end
  endtask

  task automatic run_mul(input logic [31:0] x, input logic [31:0] y);
    int start;
    start = n_done;
    mul_q.push_back(mul_model(x, y));
    mul_t_q.push_back(cyc + 34);
    apply(14'h0004, x, y);
    apply(14'h0004, $urandom, $urandom);
    wait_mul(start);
    repeat (3) apply(14'h0004, $urandom, $urandom);
    apply(14'h0000, 32'd0, 32'd0);
  endtask

  logic        prev_end = 1'b0;
  logic [63:0] last_prod = '0;

  always @(negedge clk) begin
    alu_exp_t e;
    if (alu_q.size() > 0) begin
      e = alu_q.pop_front();
      chk("alu_result", {32'd0, alu_result}, {32'd0, e.res});
      chk("div_odd", {32'd0, div_odd}, {32'd0, e.rem});
    end
    if (mult_end && !prev_end) begin
      if (mul_q.size() == 0) begin
        chk("unexpected_mult_end", 64'd1, 64'd0);
      end else begin
        chk("product", product, mul_q.pop_front());
        chk("mult_latency", 64'(cyc), 64'(mul_t_q.pop_front()));
      end
      last_prod = product;
      n_done++;
    end else if (prev_end) begin
      chk(mult_end ? "product_hold" : "product_keep", product, last_prod);
    end
    prev_end = mult_end;
  end

  always @(negedge resetn) begin
    #1;
    chk("reset_product", product, 64'd0);
    chk("reset_mult_end", {63'd0, mult_end}, 64'd0);
  end

  initial begin
    logic [13:0] c;
    int          idx, start;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    apply(14'h0001, 32'h2223, 32'h2222);
    apply(14'h0002, 32'd25, 32'd2);
    apply(14'h0002, 32'd0, 32'd1);
    apply(14'h0008, 32'd564, 32'd7);
    apply(14'h0008, 32'd5, 32'd0);
    apply(14'h0010, 32'hFFFF_FFFF, 32'd1);
    apply(14'h0020, 32'hFFFF_FFFF, 32'd1);
    apply(14'h0080, 32'hA, 32'h5);
    apply(14'h0200, 32'h1, 32'h1111);
    apply(14'h0400, 32'd4, 32'hF000_0000);
    apply(14'h1000, 32'd4, 32'hF000_0000);
    apply(14'h2000, 32'd4, 32'hF000_0000);
    apply(14'h0800, 32'h1234_5678, 32'hBFC0);
    apply(14'h0000, 32'h1234_5678, 32'h9ABC_DEF0);
    apply(14'h0004, 32'h1234_5678, 32'h9ABC_DEF0);
    apply(14'h0000, 32'd0, 32'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        c = 14'($urandom) & 14'h3FFB;
      end else begin
        idx = $urandom_range(0, 12);
        if (idx >= 2) idx++;
        c = 14'd1 << idx;
      end
      apply(c, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
               ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 9)) : $urandom);
    end

    run_mul(32'd10000000, 32'd20);
    run_mul(32'hFFFF_FFFD, 32'd7);
    run_mul(32'h8000_0000, 32'h8000_0000);
    run_mul(32'h8000_0000, 32'd1);
    run_mul(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    for (int n = 0; n < 5; n++) run_mul($urandom, $urandom);

    // Drop MUL mid-operation: must abort silently, then a new multiply still works.
    apply(14'h0004, 32'd123, 32'd456);
    repeat (5) begin @(posedge clk); #1; end
    apply(14'h0000, 32'd0, 32'd0);
    run_mul(32'd123, 32'd456);

    // Asynchronous reset at step 10, then a fresh multiply with MUL still held.
    apply(14'h0004, 32'hFFFF_FF00, 32'd77);
    repeat (10) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    start = n_done;
    mul_q.push_back(mul_model(32'hFFFF_FF00, 32'd77));
    mul_t_q.push_back(cyc + 34);
    wait_mul(start);
    apply(14'h0000, 32'd0, 32'd0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
